byte_mem_arbiter: RTL and testbench

//  Shares one byte-wide memory port between the bridge loader (bridge-to-bytes byte sequencer) and a core-side

---
 rtl/byte_mem_arbiter_pkg.sv | 21 ++
 rtl/byte_mem_arbiter_if.sv | 51 +++++
 rtl/byte_mem_arbiter_rd_tag_pipe.sv | 33 +++
 rtl/byte_mem_arbiter.sv | 129 ++++++++++++
 tb/tb_byte_mem_arbiter.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/byte_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : byte_mem_pkg
//  Purpose  : Shared types and helpers for the byte memory port arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package byte_mem_pkg;

   typedef enum logic [1:0] {
      CORE   = 2'd0,
      LOADER = 2'd1,
      DRAIN  = 2'd2
   } arb_state_t;

   // Counter must hold READ_LATENCY+1, the drain window length.
   function automatic int drain_cnt_w(input int read_latency);
      return $clog2(read_latency + 2);
   endfunction

endpackage
`default_nettype wire

// File: rtl/byte_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : byte_mem_arbiter_if
//  Purpose  : Loader, core and RAM bus signals around the byte memory arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface byte_mem_arbiter_if #(
   parameter int ADDR_W = 32
);
   logic              ldr_busy;
   logic [ADDR_W-1:0] ldr_address;
   logic              ldr_wr;
   logic [7:0]        ldr_wr_data;
   logic              ldr_rd;
   logic [7:0]        ldr_rd_data;

   logic              core_req;
   logic              core_wr;
   logic [ADDR_W-1:0] core_addr;
   logic [7:0]        core_wr_data;
   logic              core_ack;
   logic              core_rd_valid;
   logic [7:0]        core_rd_data;

   logic [ADDR_W-1:0] mem_address;
   logic              mem_wr;
   logic [7:0]        mem_wr_data;
   logic              mem_rd;
   logic [7:0]        mem_rd_data;

   // Requester/RAM side of the bus.
   modport master (
      output ldr_busy, ldr_address, ldr_wr, ldr_wr_data, ldr_rd,
      input  ldr_rd_data,
      output core_req, core_wr, core_addr, core_wr_data,
      input  core_ack, core_rd_valid, core_rd_data,
      input  mem_address, mem_wr, mem_wr_data, mem_rd,
      output mem_rd_data
   );

   // Arbiter side of the bus.
   modport slave (
      input  ldr_busy, ldr_address, ldr_wr, ldr_wr_data, ldr_rd,
      output ldr_rd_data,
      input  core_req, core_wr, core_addr, core_wr_data,
      output core_ack, core_rd_valid, core_rd_data,
      output mem_address, mem_wr, mem_wr_data, mem_rd,
      input  mem_rd_data
   );
endinterface
`default_nettype wire

// File: rtl/byte_mem_arbiter_rd_tag_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : rd_tag_pipe
//  Purpose  : DEPTH-stage shift register carrying the one-bit core-read tag.
//  Revision : 1.0 - initial release
// ============================================================================
module rd_tag_pipe #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic tag_in,
   output logic tag_out
);
   logic [DEPTH-1:0] sr;

   generate
      if (DEPTH == 1) begin : g_single
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) sr <= '0;
            else          sr <= tag_in;
         end
      end else begin : g_multi
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) sr <= '0;
            else          sr <= {sr[DEPTH-2:0], tag_in};
         end
      end
   endgenerate

   assign tag_out = sr[DEPTH-1];
endmodule
`default_nettype wire

// File: rtl/byte_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : byte_mem_arbiter
//  Purpose  : Shares one byte RAM port between the blind-strobing loader and
//             a req/ack core requester; read bytes are routed by owner tag.
//  Revision : 1.0 - initial release
// ============================================================================
module byte_mem_arbiter
   import byte_mem_pkg::*;
#(
   parameter int READ_LATENCY = 2,
   parameter int ADDR_W       = 32
) (
   input  logic                 clk,
   input  logic                 reset_n,
   byte_mem_arbiter_if.slave    bus,
   output logic                 conflict
);
   localparam int              CNT_W    = drain_cnt_w(READ_LATENCY);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   arb_state_t        state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic              ldr_strobe;
   logic              ack_int;
   logic              use_ldr;
   logic [ADDR_W-1:0] addr_mux;
   logic [7:0]        wdata_mux;
   logic              wr_mux;
   logic              rd_mux;
   logic              tag_out;
   logic              rd_valid_q;
   logic [7:0]        rd_data_q;

   assign ldr_strobe = bus.ldr_wr | bus.ldr_rd;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= CORE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         CORE: begin
            if (bus.ldr_busy) state_nxt = LOADER;
         end
         LOADER: begin
            if (!bus.ldr_busy) begin
               state_nxt = DRAIN;
               cnt_nxt   = CNT_LOAD;
            end
         end
         DRAIN: begin
            if (bus.ldr_busy) begin
               state_nxt = LOADER;
            end else if (cnt == CNT_ONE) begin
               state_nxt = CORE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt - CNT_ONE;
            end
         end
         default: begin
            state_nxt = CORE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // A blind loader strobe always wins the port, even in CORE.
   always_comb begin
      ack_int = 1'b0;
      use_ldr = 1'b0;
      case (state)
         CORE: begin
            if (ldr_strobe)         use_ldr = 1'b1;
            else if (!bus.ldr_busy) ack_int = bus.core_req & reset_n;
         end
         LOADER, DRAIN: use_ldr = 1'b1;
         default: ;
      endcase
      addr_mux  = use_ldr ? bus.ldr_address : bus.core_addr;
      wdata_mux = use_ldr ? bus.ldr_wr_data : bus.core_wr_data;
      wr_mux    = reset_n & (use_ldr ? bus.ldr_wr : (ack_int &  bus.core_wr));
      rd_mux    = reset_n & (use_ldr ? bus.ldr_rd : (ack_int & ~bus.core_wr));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                        conflict <= 1'b0;
      else if (state == CORE && ldr_strobe) conflict <= 1'b1;
   end

   rd_tag_pipe #(
      .DEPTH (READ_LATENCY)
   ) u_rd_tag_pipe (
      .clk     (clk),
      .reset_n (reset_n),
      .tag_in  (ack_int & ~bus.core_wr),
      .tag_out (tag_out)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= 8'h00;
      end else begin
         rd_valid_q <= tag_out;
         if (tag_out) rd_data_q <= bus.mem_rd_data;
      end
   end

   assign bus.core_ack      = ack_int;
   assign bus.core_rd_valid = rd_valid_q;
   assign bus.core_rd_data  = rd_data_q;
   assign bus.ldr_rd_data   = bus.mem_rd_data;
   assign bus.mem_address   = addr_mux;
   assign bus.mem_wr_data   = wdata_mux;
   assign bus.mem_wr        = wr_mux;
   assign bus.mem_rd        = rd_mux;
endmodule
`default_nettype wire

// File: tb/tb_byte_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_byte_mem_arbiter
//  Purpose  : Directed self-checking bench for byte_mem_arbiter with a
//             two-cycle-latency RAM model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_byte_mem_arbiter;
   logic clk = 1'b0;
   logic reset_n;
   logic conflict;
   int   n_vec = 0;
   int   n_err = 0;

   logic [7:0] ram [0:255];
   logic [7:0] ram_s1, ram_s2;

   byte_mem_arbiter_if #(.ADDR_W(32)) bus ();

   byte_mem_arbiter #(
      .READ_LATENCY (2),
      .ADDR_W       (32)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .bus      (bus.slave),
      .conflict (conflict)
   );

   always #5 clk = ~clk;

   // RAM: address sampled in cycle T, data presented in cycle T+2.
   always @(posedge clk) begin
      if (!reset_n) begin
         ram[8'h20] <= 8'hC3;
         ram[8'h21] <= 8'h11;
         ram[8'h22] <= 8'h22;
      end else if (bus.mem_wr) begin
         ram[bus.mem_address[7:0]] <= bus.mem_wr_data;
      end
      ram_s1 <= ram[bus.mem_address[7:0]];
      ram_s2 <= ram_s1;
   end
   assign bus.mem_rd_data = ram_s2;

   task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      logic [7:0] exp_b2b [0:2];
      exp_b2b[0] = 8'h11;
      exp_b2b[1] = 8'h22;
      exp_b2b[2] = 8'h5A;

      reset_n          = 1'b0;
      bus.ldr_busy     = 1'b0;
      bus.ldr_address  = '0;
      bus.ldr_wr       = 1'b0;
      bus.ldr_wr_data  = 8'h00;
      bus.ldr_rd       = 1'b0;
      bus.core_req     = 1'b1;
      bus.core_wr      = 1'b0;
      bus.core_addr    = '0;
      bus.core_wr_data = 8'h00;

      // Reset state
      repeat (3) tick();
      settle();
      check_vec("rst_ack",      bus.core_ack,      0);
      check_vec("rst_mem_rd",   bus.mem_rd,        0);
      check_vec("rst_mem_wr",   bus.mem_wr,        0);
      check_vec("rst_rd_valid", bus.core_rd_valid, 0);
      check_vec("rst_rd_data",  bus.core_rd_data,  0);
      check_vec("rst_conflict", conflict,          0);
      bus.core_req = 1'b0;
      reset_n      = 1'b1;

      // 1: core write
      tick();
      bus.core_req = 1'b1; bus.core_wr = 1'b1;
      bus.core_addr = 32'h10; bus.core_wr_data = 8'h5A;
      settle();
      check_vec("wr_ack",      bus.core_ack,    1);
      check_vec("wr_mem_wr",   bus.mem_wr,      1);
      check_vec("wr_mem_rd",   bus.mem_rd,      0);
      check_vec("wr_mem_addr", bus.mem_address, 32'h10);
      check_vec("wr_mem_data", bus.mem_wr_data, 8'h5A);

      // 2: single core read, latency T+3
      tick();
      bus.core_wr = 1'b0; bus.core_addr = 32'h20;
      settle();
      check_vec("rd_ack",      bus.core_ack,    1);
      check_vec("rd_mem_rd",   bus.mem_rd,      1);
      check_vec("rd_mem_addr", bus.mem_address, 32'h20);
      tick(); bus.core_req = 1'b0; settle();
      check_vec("rd_t1_valid", bus.core_rd_valid, 0);
      tick(); settle();
      check_vec("rd_t2_valid", bus.core_rd_valid, 0);
      check_vec("rd_t2_ldr_rd_data", bus.ldr_rd_data, 8'hC3);
      tick(); settle();
      check_vec("rd_t3_valid", bus.core_rd_valid, 1);
      check_vec("rd_t3_data",  bus.core_rd_data,  8'hC3);
      tick(); settle();
      check_vec("rd_t4_valid", bus.core_rd_valid, 0);
      check_vec("rd_t4_hold",  bus.core_rd_data,  8'hC3);

      // 2b: three back-to-back reads
      for (int i = 0; i < 6; i++) begin
         tick();
         if (i < 3) begin
            bus.core_req  = 1'b1;
            bus.core_addr = (i == 2) ? 32'h10 : 32'h21 + 32'(i);
         end else begin
            bus.core_req = 1'b0;
         end
         settle();
         if (i < 3) begin
            check_vec("b2b_ack",   bus.core_ack,      1);
            check_vec("b2b_idle",  bus.core_rd_valid, 0);
         end else begin
            check_vec("b2b_valid", bus.core_rd_valid, 1);
            check_vec("b2b_data",  bus.core_rd_data,  exp_b2b[i-3]);
         end
      end
      tick(); settle();
      check_vec("b2b_end_valid", bus.core_rd_valid, 0);

      // 3: loader busy 12 cycles, core_req held
      bus.core_req = 1'b1; bus.core_wr = 1'b1;
      bus.core_addr = 32'h30; bus.core_wr_data = 8'h77;
      bus.ldr_address = 32'h40;
      for (int j = 0; j < 17; j++) begin
         tick();
         bus.ldr_busy    = (j < 12);
         bus.ldr_wr      = (j == 14);
         bus.ldr_wr_data = 8'hEE;
         settle();
         check_vec("busy_ack", bus.core_ack, (j == 16) ? 1 : 0);
         if (j == 5) check_vec("loader_addr", bus.mem_address, 32'h40);
         if (j == 14) check_vec("drain_ldr_wr", bus.mem_wr, 1);
         if (j == 15) check_vec("drain_no_conflict", conflict, 0);
      end

      // 4: busy re-asserts at drain count 2
      for (int j = 0; j < 13; j++) begin
         tick();
         bus.ldr_busy = (j < 4) || (j == 6) || (j == 7);
         settle();
         check_vec("rebusy_ack", bus.core_ack, (j == 12) ? 1 : 0);
      end

      // 5: loader strobe in CORE
      tick();
      bus.core_wr = 1'b0; bus.core_addr = 32'h50;
      bus.ldr_wr = 1'b1; bus.ldr_address = 32'h60; bus.ldr_wr_data = 8'hA5;
      settle();
      check_vec("cfl_ack",      bus.core_ack,    0);
      check_vec("cfl_mem_wr",   bus.mem_wr,      1);
      check_vec("cfl_mem_rd",   bus.mem_rd,      0);
      check_vec("cfl_mem_addr", bus.mem_address, 32'h60);
      check_vec("cfl_mem_data", bus.mem_wr_data, 8'hA5);
      check_vec("cfl_pre",      conflict,        0);
      tick();
      bus.ldr_wr = 1'b0; bus.core_req = 1'b0;
      settle();
      check_vec("cfl_set", conflict, 1);
      repeat (3) tick();
      settle();
      check_vec("cfl_sticky",   conflict,          1);
      check_vec("cfl_no_valid", bus.core_rd_valid, 0);

      // 6: reset with two core reads in flight
      tick();
      bus.core_req = 1'b1; bus.core_addr = 32'h21;
      settle();
      check_vec("inflight_ack0", bus.core_ack, 1);
      tick();
      bus.core_addr = 32'h22;
      settle();
      check_vec("inflight_ack1", bus.core_ack, 1);
      tick();
      reset_n = 1'b0;
      settle();
      check_vec("mrst_ack",      bus.core_ack,      0);
      check_vec("mrst_mem_rd",   bus.mem_rd,        0);
      check_vec("mrst_conflict", conflict,          0);
      check_vec("mrst_valid",    bus.core_rd_valid, 0);
      check_vec("mrst_data",     bus.core_rd_data,  0);
      bus.core_req = 1'b0;
      repeat (2) tick();
      reset_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick(); settle();
         check_vec("post_rst_valid", bus.core_rd_valid, 0);
      end
      check_vec("post_rst_data", bus.core_rd_data, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire
